// File: rtl/mod_counter_pkg.sv
// Shared definitions for the mod_counter family: FSM encoding, mode constants
// and the prescaler phase-width helper.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Phase register width for a given prescale ratio; never narrower than 1 bit.
    function automatic int ps_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Step-rate divider: emits one strobe every PRESCALE enabled cycles and
// returns to phase 0 on restart.
module mod_counter_prescaler
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic strobe
);

    localparam int            PW   = ps_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign strobe = en && !restart && (phase == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase <= '0;
        else if (restart)
            phase <= '0;
        else if (en)
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down counter with programmable modulus, wrap/saturate modes and a
// terminal-count pulse. Define MOD_COUNTER_PRESCALE_EN to divide the step rate.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = longint'(1) << WIDTH,
    parameter int     PRESCALE = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_bound,
    output logic             busy
);

    if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 ||
        MODULUS > (longint'(1) << WIDTH) || PRESCALE < 1) begin : g_bad_cfg
        $error("mod_counter: illegal parameter set");
    end

    // Top count value carried one bit wider so MODULUS-1 never aliases.
    localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);

    state_t           state;
    logic             halt_dir;
    logic [WIDTH:0]   cur, inc, dec, ld_ext;
    logic [WIDTH-1:0] ld_clamp;
    logic             at_top, at_zero;
    logic [WIDTH-1:0] nxt;
    logic             nxt_tc, hit, halt_req, step, ctl;

    assign cur      = {1'b0, count};
    assign inc      = cur + 1'b1;
    assign dec      = cur - 1'b1;
    assign at_top   = (cur == TOP);
    assign at_zero  = (count == '0);
    assign at_bound = up_dn ? at_top : at_zero;

    assign ld_ext   = {1'b0, load_val};
    assign ld_clamp = (ld_ext > TOP) ? TOP[WIDTH-1:0] : load_val;
    assign ctl      = clear || load;

    // Result of one step; hit flags that the step touched a bound.
    always_comb begin
        nxt    = count;
        nxt_tc = 1'b0;
        hit    = 1'b0;
        if (up_dn) begin
            if (at_top) begin
                hit = 1'b1;
                if (sat == MODE_WRAP) begin
                    nxt    = '0;
                    nxt_tc = 1'b1;
                end
            end else begin
                nxt = inc[WIDTH-1:0];
                if (sat == MODE_SAT && inc == TOP) begin
                    nxt_tc = 1'b1;
                    hit    = 1'b1;
                end
            end
        end else begin
            if (at_zero) begin
                hit = 1'b1;
                if (sat == MODE_WRAP) begin
                    nxt    = TOP[WIDTH-1:0];
                    nxt_tc = 1'b1;
                end
            end else begin
                nxt = dec[WIDTH-1:0];
                if (sat == MODE_SAT && dec == '0) begin
                    nxt_tc = 1'b1;
                    hit    = 1'b1;
                end
            end
        end
    end

    assign halt_req = (sat == MODE_SAT) && hit;

`ifdef MOD_COUNTER_PRESCALE_EN
    logic ps_en, ps_restart, ps_strobe, pend;

    // The IDLE->RUN arming cycle still advances the phase; a strobe landing
    // there is held in pend and spent on the first RUN cycle.
    assign ps_en      = en && (state != HALT);
    assign ps_restart = ctl || (state == HALT);
    assign step       = (state == RUN) && en && (ps_strobe || pend);

    mod_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (ps_en),
        .restart (ps_restart),
        .strobe  (ps_strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend <= 1'b0;
        else if (ps_restart)
            pend <= 1'b0;
        else if (state == IDLE && ps_strobe)
            pend <= 1'b1;
        else if (step)
            pend <= 1'b0;
    end
`else
    assign step = (state == RUN) && en;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            tc       <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
            halt_dir <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clear)
                count <= '0;
            else if (load)
                count <= ld_clamp;
            else if (step) begin
                count <= nxt;
                tc    <= nxt_tc;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (step && !ctl && halt_req) begin
                        state    <= HALT;
                        busy     <= 1'b0;
                        halt_dir <= up_dn;
                    end
                end
                HALT: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ctl || up_dn != halt_dir) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
